// File: rtl/vga_pixel_fetch_if.sv
// Pixel-fetch bus: pointer-stage stream in, shared ROM address/data, RGB and syncs out.
// The pixel-fetch stage connects through the slave modport; its upstream/ROM/DAC side uses master.
interface vga_pixel_fetch_if #(
  parameter int ADDR_W = 19,
  parameter int PIX_W  = 8
);
  logic [ADDR_W-1:0] ROMAddrIn;
  logic [1:0]        ROMCSIn;
  logic              HSyncIn;
  logic              VSyncIn;
  logic              VideoOnIn;
  logic [ADDR_W-1:0] RomAddr;
  logic [PIX_W-1:0]  BgData;
  logic [PIX_W-1:0]  DigData;
  logic [PIX_W-1:0]  IndData;
  logic [PIX_W-1:0]  RGB;
  logic              HSyncOut;
  logic              VSyncOut;

  modport slave (
    input  ROMAddrIn, ROMCSIn, HSyncIn, VSyncIn, VideoOnIn,
    input  BgData, DigData, IndData,
    output RomAddr, RGB, HSyncOut, VSyncOut
  );

  modport master (
    output ROMAddrIn, ROMCSIn, HSyncIn, VSyncIn, VideoOnIn,
    output BgData, DigData, IndData,
    input  RomAddr, RGB, HSyncOut, VSyncOut
  );
endinterface

// File: rtl/vga_pixel_fetch.sv
// vga_pixel_fetch: registers the pointer-stage ROM address onto the shared ROM bus,
// selects background/digit/indicator data into a 3-3-2 RGB pixel three clocks later,
// and delays the syncs four clocks so they line up with RGB. The indicator region
// blinks at a frame-counted rate while the chrono alarm rings.
// Optional feature: define TEST_PATTERN_EN to add the TestPattern input and a
// colour-bar generator that replaces the ROM pixel while TestPattern is high.
module vga_pixel_fetch #(
  parameter int         ADDR_W       = 19,
  parameter int         PIX_W        = 8,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] BLINK_COLOR  = 8'h00
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RingIn,
`ifdef TEST_PATTERN_EN
  input  logic TestPattern,
`endif
  vga_pixel_fetch_if.slave bus
);

  typedef enum logic {
    PhaseOn  = 1'b0,
    PhaseOff = 1'b1
  } blinkPhase_t;

  localparam logic [7:0] LastFrame = 8'(BLINK_FRAMES - 1);

  logic [ADDR_W-1:0] romAddrQ;
  logic [1:0]        cs1;
  logic [1:0]        cs2;
  logic [3:0]        hsPipe;
  logic [3:0]        vsPipe;
  logic [2:0]        vidPipe;
  logic [PIX_W-1:0]  rgbQ;
  logic [PIX_W-1:0]  romPixel;
  logic [PIX_W-1:0]  pixelNext;

  logic              frameEvent;
  logic              ringQ;
  logic              ringNext;
  logic [7:0]        frameCnt;
  logic [7:0]        frameCntNext;
  blinkPhase_t       phase;
  blinkPhase_t       phaseNext;

  // vsPipe[0] is the previous VSyncIn, so this is a one-clock pulse on its falling edge
  assign frameEvent = vsPipe[0] & ~bus.VSyncIn;

  // Address/chip-select pipe (S1, S2) and the sync/video delay lines; bit 0 is the newest sample.
  // Video-on only needs three stages here because the RGB register itself is the fourth.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      romAddrQ <= '0;
      cs1      <= '0;
      cs2      <= '0;
      hsPipe   <= '1;
      vsPipe   <= '1;
      vidPipe  <= '0;
    end else begin
      romAddrQ <= bus.ROMAddrIn;
      cs1      <= bus.ROMCSIn;
      cs2      <= cs1;
      hsPipe   <= {hsPipe[2:0], bus.HSyncIn};
      vsPipe   <= {vsPipe[2:0], bus.VSyncIn};
      vidPipe  <= {vidPipe[1:0], bus.VideoOnIn};
    end
  end

  // Blink state register: alarm level, frame counter and on/off phase
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ringQ    <= 1'b0;
      frameCnt <= '0;
      phase    <= PhaseOn;
    end else begin
      ringQ    <= ringNext;
      frameCnt <= frameCntNext;
      phase    <= phaseNext;
    end
  end

  // Blink next-state: only frame boundaries move anything, and the alarm stopping
  // forces the phase back on so the next ring always starts with a visible indicator
  always_comb begin
    ringNext     = ringQ;
    frameCntNext = frameCnt;
    phaseNext    = phase;
    if (frameEvent) begin
      ringNext = RingIn;
      if (ringQ && !RingIn) begin
        frameCntNext = '0;
        phaseNext    = PhaseOn;
      end else if (frameCnt >= LastFrame) begin
        frameCntNext = '0;
        phaseNext    = (phase == PhaseOn) ? PhaseOff : PhaseOn;
      end else begin
        frameCntNext = frameCnt + 8'd1;
      end
    end
  end

`ifdef TEST_PATTERN_EN
  logic [9:0]       barCnt;
  logic [PIX_W-1:0] barColor;

  // Bar counter restarts on every blanked pixel so each line starts at bar 0
  always_ff @(posedge CLK) begin
    if (RESET) begin
      barCnt <= '0;
    end else if (!vidPipe[2]) begin
      barCnt <= '0;
    end else begin
      barCnt <= barCnt + 10'd1;
    end
  end

  // Eight 128-pixel colour bars
  always_comb begin
    barColor = '0;
    case (barCnt[9:7])
      3'd0:    barColor = PIX_W'(8'hFF);
      3'd1:    barColor = PIX_W'(8'hFC);
      3'd2:    barColor = PIX_W'(8'h1F);
      3'd3:    barColor = PIX_W'(8'h1C);
      3'd4:    barColor = PIX_W'(8'hE3);
      3'd5:    barColor = PIX_W'(8'hE0);
      3'd6:    barColor = PIX_W'(8'h03);
      default: barColor = PIX_W'(8'h00);
    endcase
  end
`endif

  // S3 pixel select: ROM mux on the stage-2 chip select, optional test bars, then blanking
  always_comb begin
    romPixel = '0;
    case (cs2)
      2'b00:   romPixel = bus.BgData;
      2'b01:   romPixel = bus.DigData;
      2'b11:   romPixel = (ringQ && (phase == PhaseOff)) ? PIX_W'(BLINK_COLOR) : bus.IndData;
      default: romPixel = '0;
    endcase
    pixelNext = romPixel;
`ifdef TEST_PATTERN_EN
    if (TestPattern) begin
      pixelNext = barColor;
    end
`endif
    if (!vidPipe[2]) begin
      pixelNext = '0;
    end
  end

  // S3 output register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rgbQ <= '0;
    end else begin
      rgbQ <= pixelNext;
    end
  end

  assign bus.RomAddr  = romAddrQ;
  assign bus.RGB      = rgbQ;
  assign bus.HSyncOut = hsPipe[3];
  assign bus.VSyncOut = vsPipe[3];

endmodule
